// File: rtl/occupancy_update_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : occupancy_pkg
// Description : Shared types and default increments for the occupancy updater.
// Revision    : 1.0 - initial release
// ============================================================================
package occupancy_pkg;

    localparam int c_CELL_WIDTH_DEFAULT    = 8;
    localparam int c_LOG_ODDS_OCC_DEFAULT  = 9;
    localparam int c_LOG_ODDS_FREE_DEFAULT = -3;

    typedef enum logic [1:0] {
        RUN           = 2'd0,
        CLEAR_PENDING = 2'd1,
        CLEARING      = 2'd2
    } occ_state_t;

    typedef logic signed [c_CELL_WIDTH_DEFAULT-1:0] log_odds_t;

endpackage
`default_nettype wire

// File: rtl/occupancy_update_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : occupancy_update_if
// Description : Update request, map RAM port and status signals of the updater.
// Revision    : 1.0 - initial release
// ============================================================================
interface occupancy_update_if
    import occupancy_pkg::*;
#(
    parameter int X_WIDTH    = 8,
    parameter int Y_WIDTH    = 8,
    parameter int CELL_WIDTH = c_CELL_WIDTH_DEFAULT
) ();

    logic                         write_enable;
    logic                         cell_is_free;
    logic [X_WIDTH-1:0]           cell_x;
    logic [Y_WIDTH-1:0]           cell_y;
    logic                         clear;
    logic                         rd_en;
    logic [X_WIDTH+Y_WIDTH-1:0]   rd_addr;
    logic [CELL_WIDTH-1:0]        rd_data;
    logic                         wr_en;
    logic [X_WIDTH+Y_WIDTH-1:0]   wr_addr;
    logic [CELL_WIDTH-1:0]        wr_data;
    logic                         occupancy_busy;
    logic                         overrun;

    // Upstream ray tracer plus the map RAM
    modport master (
        output write_enable, cell_is_free, cell_x, cell_y, clear, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, occupancy_busy, overrun
    );

    modport slave (
        input  write_enable, cell_is_free, cell_x, cell_y, clear, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, occupancy_busy, overrun
    );

endinterface
`default_nettype wire

// File: rtl/occupancy_update_sat_add.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : log_odds_sat_add
// Description : Combinational signed adder clamped to the CELL_WIDTH range.
// Revision    : 1.0 - initial release
// ============================================================================
module log_odds_sat_add #(
    parameter int CELL_WIDTH = 8
) (
    input  wire logic signed [CELL_WIDTH-1:0] i_old,
    input  wire logic signed [CELL_WIDTH-1:0] i_inc,
    output logic      signed [CELL_WIDTH-1:0] o_sum
);

    localparam logic signed [CELL_WIDTH-1:0] c_MAX = {1'b0, {(CELL_WIDTH-1){1'b1}}};
    localparam logic signed [CELL_WIDTH-1:0] c_MIN = {1'b1, {(CELL_WIDTH-1){1'b0}}};

    logic signed [CELL_WIDTH:0] w_sum;

    assign w_sum = {i_old[CELL_WIDTH-1], i_old} + {i_inc[CELL_WIDTH-1], i_inc};

    // The two top bits of the widened sum disagree only on overflow
    always_comb begin
        o_sum = w_sum[CELL_WIDTH-1:0];
        if (w_sum[CELL_WIDTH] != w_sum[CELL_WIDTH-1]) begin
            o_sum = w_sum[CELL_WIDTH] ? c_MIN : c_MAX;
        end
    end

endmodule
`default_nettype wire

// File: rtl/occupancy_update.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : occupancy_update
// Description : Pipelined log-odds read-modify-write with forwarding and map clear sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module occupancy_update
    import occupancy_pkg::*;
#(
    parameter int X_WIDTH       = 8,
    parameter int Y_WIDTH       = 8,
    parameter int CELL_WIDTH    = c_CELL_WIDTH_DEFAULT,
    parameter int LOG_ODDS_OCC  = c_LOG_ODDS_OCC_DEFAULT,
    parameter int LOG_ODDS_FREE = c_LOG_ODDS_FREE_DEFAULT
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    occupancy_update_if.slave bus
);

    localparam int c_ADDR_WIDTH = X_WIDTH + Y_WIDTH;
    localparam logic signed [CELL_WIDTH-1:0] c_INC_OCC  = CELL_WIDTH'(LOG_ODDS_OCC);
    localparam logic signed [CELL_WIDTH-1:0] c_INC_FREE = CELL_WIDTH'(LOG_ODDS_FREE);

    occ_state_t                      r_state;
    logic                            r_s1_valid;
    logic                            r_s1_free;
    logic        [c_ADDR_WIDTH-1:0]  r_s1_addr;
    logic                            r_s2_valid;
    logic                            r_wr_en;
    logic        [c_ADDR_WIDTH-1:0]  r_wr_addr;
    logic signed [CELL_WIDTH-1:0]    r_wr_data;
    logic                            r_s3_valid;
    logic        [c_ADDR_WIDTH-1:0]  r_s3_addr;
    logic signed [CELL_WIDTH-1:0]    r_s3_data;
    logic        [c_ADDR_WIDTH:0]    r_sweep_cnt;
    logic                            r_overrun;

    logic                            w_accept;
    logic                            w_sweep_start;
    logic        [c_ADDR_WIDTH-1:0]  w_rd_addr;
    logic signed [CELL_WIDTH-1:0]    w_old;
    logic signed [CELL_WIDTH-1:0]    w_inc;
    logic signed [CELL_WIDTH-1:0]    w_new;

    assign w_rd_addr     = {bus.cell_y, bus.cell_x};
    assign w_accept      = reset_n & bus.write_enable & (r_state != CLEARING);
    assign w_sweep_start = (r_state == CLEAR_PENDING) & ~r_s1_valid & ~r_s2_valid
                         & ~bus.write_enable;
    assign w_inc         = r_s1_free ? c_INC_FREE : c_INC_OCC;

    // Newer in-flight values override the RAM, which has not seen them yet
    always_comb begin
        w_old = bus.rd_data;
        if (r_s2_valid && (r_wr_addr == r_s1_addr)) begin
            w_old = r_wr_data;
        end else if (r_s3_valid && (r_s3_addr == r_s1_addr)) begin
            w_old = r_s3_data;
        end
    end

    log_odds_sat_add #(
        .CELL_WIDTH (CELL_WIDTH)
    ) u_sat_add (
        .i_old (w_old),
        .i_inc (w_inc),
        .o_sum (w_new)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= RUN;
            r_s1_valid  <= 1'b0;
            r_s1_free   <= 1'b0;
            r_s1_addr   <= '0;
            r_s2_valid  <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_addr   <= '0;
            r_s3_data   <= '0;
            r_sweep_cnt <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_addr  <= w_rd_addr;
            r_s1_free  <= bus.cell_is_free;
            r_s2_valid <= r_s1_valid;
            r_wr_en    <= 1'b0;

            if (r_s1_valid) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_s1_addr;
                r_wr_data <= w_new;
            end

            if (r_s2_valid) begin
                r_s3_valid <= 1'b1;
                r_s3_addr  <= r_wr_addr;
                r_s3_data  <= r_wr_data;
            end

            case (r_state)
                RUN: begin
                    if (bus.clear) begin
                        r_state <= CLEAR_PENDING;
                    end
                end
                CLEAR_PENDING: begin
                    if (w_sweep_start) begin
                        r_state     <= CLEARING;
                        r_sweep_cnt <= '0;
                        r_s3_valid  <= 1'b0;
                    end
                end
                CLEARING: begin
                    if (bus.write_enable) begin
                        r_overrun <= 1'b1;
                    end
                    // Counter MSB set means the last address is on wr_* this cycle
                    if (r_sweep_cnt[c_ADDR_WIDTH]) begin
                        r_state <= RUN;
                    end else begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= r_sweep_cnt[c_ADDR_WIDTH-1:0];
                        r_wr_data   <= '0;
                        r_sweep_cnt <= r_sweep_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign bus.rd_en          = w_accept;
    assign bus.rd_addr        = w_rd_addr;
    assign bus.wr_en          = r_wr_en;
    assign bus.wr_addr        = r_wr_addr;
    assign bus.wr_data        = r_wr_data;
    assign bus.occupancy_busy = r_s1_valid | r_s2_valid | (r_state != RUN);
    assign bus.overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_occupancy_update.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_occupancy_update
// Description : Randomized bench for occupancy_update against a cell-map reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_occupancy_update;
    import occupancy_pkg::*;

    localparam int c_NCELL = 65536;
    localparam int c_HIST  = 131072;
    localparam int c_BIG   = 32'h7fffffff;

    typedef struct {
        int c;
        int a;
        int d;
    } exp_wr_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    occupancy_update_if #(.X_WIDTH(8), .Y_WIDTH(8), .CELL_WIDTH(8)) bus ();

    occupancy_update #(
        .X_WIDTH       (8),
        .Y_WIDTH       (8),
        .CELL_WIDTH    (8),
        .LOG_ODDS_OCC  (9),
        .LOG_ODDS_FREE (-3)
    ) u_dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Map RAM: 1-cycle read, read-during-write returns old data
    log_odds_t r_mem   [0:c_NCELL-1];
    log_odds_t ref_map [0:c_NCELL-1];
    log_odds_t r_rd_data;
    logic      r_load = 1'b1;
    assign bus.rd_data = r_rd_data;

    always @(posedge clock) begin
        if (r_load) begin
            r_mem <= ref_map;
        end else begin
            if (bus.rd_en) r_rd_data <= r_mem[bus.rd_addr];
            if (bus.wr_en) r_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int sat8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    // Reference model state
    exp_wr_t exp_q [$];
    bit      acc_at [0:c_HIST-1];
    bit      sweep_set   = 1'b0;
    int      sweep_s     = 0;
    bit      clear_on    = 1'b0;
    int      clr_start   = 0;
    int      clr_end     = 0;
    bit      ovr_on      = 1'b0;
    int      ovr_cyc     = 0;
    bit      exp_rd_en   = 1'b0;
    int      exp_rd_addr = 0;
    int      last_we_cyc = 0;
    int      pool [8];

    task automatic drive(input bit we, input bit free, input int a, input bit clr);
        bit in_clr;
        int v;
        @(posedge clock); #1;
        bus.write_enable = we;
        bus.cell_is_free = free;
        bus.cell_x       = 8'(a);
        bus.cell_y       = 8'(a >> 8);
        bus.clear        = clr;
        exp_rd_en        = 1'b0;
        if (!reset_n) return;
        in_clr = sweep_set && (cyc >= sweep_s - 1) && (cyc <= sweep_s + c_NCELL - 1);
        exp_rd_en   = we && !in_clr;
        exp_rd_addr = a;
        if (exp_rd_en) begin
            v = sat8(int'(ref_map[a]) + (free ? -3 : 9));
            ref_map[a] = log_odds_t'(v);
            exp_q.push_back('{c: cyc + 2, a: a, d: v & 255});
            acc_at[cyc] = 1'b1;
            last_we_cyc = cyc;
        end
        if (we && in_clr && !ovr_on) begin
            ovr_on  = 1'b1;
            ovr_cyc = cyc + 1;
        end
        if (clr && !(clear_on && cyc <= clr_end)) begin
            clear_on  = 1'b1;
            clr_start = cyc + 1;
            clr_end   = c_BIG;
            sweep_set = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 1'b0);
    endtask

    // The sweep starts once the pending clear sees an empty pipeline and no request
    task automatic arm_sweep();
        int c;
        c = (clr_start > last_we_cyc + 3) ? clr_start : last_we_cyc + 3;
        sweep_s   = c + 2;
        clr_end   = sweep_s + c_NCELL - 1;
        sweep_set = 1'b1;
    endtask

    task automatic random_stream(input int n);
        for (int i = 0; i < n; i++) begin
            int a;
            a = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535)) : pool[$urandom_range(0, 7)];
            drive($urandom_range(0, 3) != 0, 1'($urandom), a, 1'b0);
        end
    endtask

    task automatic clear_stream();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'($urandom), pool[$urandom_range(0, 7)], (i == 4) || (i == 7));
        end
        arm_sweep();
    endtask

    bit mon_busy;
    always @(negedge clock) begin
        if (!reset_n) begin
            check_value("rst_wr_en", 32'(bus.wr_en), 0);
            check_value("rst_busy", 32'(bus.occupancy_busy), 0);
            check_value("rst_overrun", 32'(bus.overrun), 0);
            check_value("rst_rd_en", 32'(bus.rd_en), 0);
        end else if (!r_load) begin
            check_value("rd_en", 32'(bus.rd_en), 32'(exp_rd_en));
            if (exp_rd_en) check_value("rd_addr", 32'(bus.rd_addr), exp_rd_addr);
            mon_busy = (cyc >= 1 && acc_at[cyc-1]) || (cyc >= 2 && acc_at[cyc-2])
                     || (clear_on && cyc >= clr_start && cyc <= clr_end);
            check_value("busy", 32'(bus.occupancy_busy), 32'(mon_busy));
            check_value("overrun", 32'(bus.overrun), 32'(ovr_on && cyc >= ovr_cyc));
            if (sweep_set && cyc >= sweep_s && cyc <= sweep_s + c_NCELL - 1) begin
                check_value("sweep_wr_en", 32'(bus.wr_en), 1);
                check_value("sweep_wr_addr", 32'(bus.wr_addr), cyc - sweep_s);
                check_value("sweep_wr_data", 32'(bus.wr_data), 0);
                ref_map[cyc - sweep_s] = '0;
            end else if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
                check_value("wr_en", 32'(bus.wr_en), 1);
                check_value("wr_addr", 32'(bus.wr_addr), exp_q[0].a);
                check_value("wr_data", 32'(bus.wr_data), exp_q[0].d);
                void'(exp_q.pop_front());
            end else begin
                check_value("wr_idle", 32'(bus.wr_en), 0);
            end
        end
    end

    initial begin
        bus.write_enable = 1'b1;
        bus.cell_is_free = 1'b0;
        bus.cell_x       = 8'h03;
        bus.cell_y       = 8'h05;
        bus.clear        = 1'b0;
        for (int i = 0; i < c_NCELL; i++) ref_map[i] = log_odds_t'($urandom);
        ref_map['h0503] = 8'sd0;
        ref_map['h0707] = 8'sd0;
        ref_map['h0101] = 8'sd0;
        ref_map['h0202] = 8'sd0;
        ref_map['h1010] = 8'sd125;
        ref_map['h2020] = -8'sd127;
        pool[0] = $urandom_range(0, 900);
        pool[1] = $urandom_range(0, 900);
        for (int i = 2; i < 8; i++) pool[i] = $urandom_range(1024, 65535);

        @(posedge clock); #1;
        r_load = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n          = 1'b1;
        bus.write_enable = 1'b0;
        idle(2);

        // Directed cases
        drive(1'b1, 1'b0, 'h0503, 1'b0);
        idle(3);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 'h0707, 1'b0);
        idle(3);
        drive(1'b1, 1'b0, 'h0101, 1'b0);
        drive(1'b1, 1'b0, 'h0202, 1'b0);
        drive(1'b1, 1'b0, 'h0101, 1'b0);
        idle(3);
        drive(1'b1, 1'b0, 'h1010, 1'b0);
        drive(1'b1, 1'b1, 'h2020, 1'b0);
        idle(3);

        random_stream(300);
        idle(3);

        // Full sweep, with a dropped write and an ignored clear inside it
        clear_stream();
        while (cyc + 1 < sweep_s + c_NCELL + 2) begin
            drive((cyc + 1) == sweep_s + 100, 1'b0, pool[2], (cyc + 1) == sweep_s + 200);
        end

        random_stream(100);
        idle(3);

        // Second sweep cut short by reset
        clear_stream();
        while (cyc + 1 < sweep_s + 1000) idle(1);
        @(posedge clock); #1;
        reset_n          = 1'b0;
        bus.write_enable = 1'b0;
        bus.clear        = 1'b0;
        #1;
        check_value("async_rst_wr_en", 32'(bus.wr_en), 0);
        check_value("async_rst_busy", 32'(bus.occupancy_busy), 0);
        exp_q.delete();
        sweep_set = 1'b0;
        clear_on  = 1'b0;
        ovr_on    = 1'b0;
        exp_rd_en = 1'b0;
        idle(3);
        @(posedge clock); #1;
        reset_n = 1'b1;
        idle(2);

        random_stream(100);
        idle(5);
        check_value("exp_q_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/occupancy_update.md
# occupancy_update

Log-odds occupancy grid updater that sits directly downstream of the Bresenham ray-tracing stage. It consumes one cell update per cycle (`write_enable`, `cell_is_free`, cell coordinates) and performs a pipelined read-modify-write of the signed log-odds value in a dual-port map RAM, with saturation and hazard forwarding. It also owns the map-wide clear sweep. It drives `occupancy_busy` back to the Bresenham control unit so that no new ray starts while updates or a clear are outstanding.

## Interface
- `X_WIDTH`, 8, cell x coordinate width
- `Y_WIDTH`, 8, cell y coordinate width
- `CELL_WIDTH`, 8, signed log-odds width
- `LOG_ODDS_OCC`, +9, signed increment for an occupied cell
- `LOG_ODDS_FREE`, -3, signed increment for a free cell
- `clock`  in  1  single system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `write_enable`  in  1  one cell update request this cycle
- `cell_is_free`  in  1  1 = apply `LOG_ODDS_FREE`, 0 = apply `LOG_ODDS_OCC`
- `cell_x`  in  X_WIDTH  cell column
- `cell_y`  in  Y_WIDTH  cell row
- `clear`  in  1  single-cycle request to zero the entire map
- `rd_en`  out  1  map RAM read enable (combinational from inputs)
- `rd_addr`  out  X_WIDTH+Y_WIDTH  read address, `{cell_y, cell_x}`
- `rd_data`  in  CELL_WIDTH  read data, valid one cycle after `rd_en`
- `wr_en`  out  1  map RAM write enable (registered)
- `wr_addr`  out  X_WIDTH+Y_WIDTH  write address (registered)
- `wr_data`  out  CELL_WIDTH  write data (registered)
- `occupancy_busy`  out  1  high while the pipeline holds work or a clear is pending or running
- `overrun`  out  1  sticky flag: a write was dropped during a sweep; cleared only by reset

## Operation
- RAM contract:
  - Synchronous read with 1-cycle latency.
  - A read and a write to the same address in the same cycle returns the old data.
- Pipeline:
  - S0 accepts a request: `rd_en=1`, `rd_addr={cell_y,cell_x}`.
  - S1 receives `rd_data` and computes the new value.
  - S2 drives `wr_*`.
  - S3 holds the last written address and data, for forwarding only.
- Forwarding in S1, in priority order:
  - If S2 is valid and its address equals the S1 address, use S2 data.
  - Else if S3 is valid and its address equals the S1 address, use S3 data.
  - Else use `rd_data`.
- Arithmetic:
  - Sign-extend the old value and the increment to CELL_WIDTH+1 bits and add.
  - Clamp the sum to [-2^(CELL_WIDTH-1), 2^(CELL_WIDTH-1)-1].
- Control FSM has three states:
  - RUN → CLEAR_PENDING on `clear`.
  - CLEAR_PENDING → CLEARING on the first cycle in which S1 and S2 are empty and `write_enable` is 0.
  - CLEARING → RUN after the write to the last address.
- Writes in RUN and CLEAR_PENDING:
  - Writes are accepted in both states.
  - Writes already in flight always complete.
- Sweep (CLEARING):
  - An address counter runs from 0 to 2^(X_WIDTH+Y_WIDTH)-1, one write of value 0 per cycle.
  - `write_enable` is ignored: no RAM access, and `overrun` is set to 1.
  - S3 is invalidated at sweep start.
- `clear` received while in CLEAR_PENDING or CLEARING is ignored.
- `occupancy_busy` = S1 valid | S2 valid | state ≠ RUN. It is decoded from registers only.

## Timing
- Latency: `write_enable` at cycle t → `wr_en` at t+2. Throughput is one update per cycle with no stalls.
- Reset values:
  - `wr_en`, `wr_addr`, `wr_data`, `overrun`, `occupancy_busy` are all 0.
  - Pipeline stages are invalid and the FSM is in RUN.
  - `rd_en` follows its inputs but is forced to 0 while `reset_n` is low.
- Reset mid-sweep or mid-stream:
  - Reset takes effect immediately and asynchronously; no further RAM writes occur.
  - The map contents are left partially updated.
- Sweep timing:
  - The first sweep write appears one cycle after entering CLEARING.
  - `occupancy_busy` falls in the cycle after the last sweep write.
- A `clear` and a `write_enable` in the same cycle while in RUN: the write is accepted and the clear becomes pending.

## Structure
- Package `occupancy_pkg`:
  - `occ_state_t` enum (RUN, CLEAR_PENDING, CLEARING).
  - `log_odds_t` typedef.
  - Default LOG_ODDS_OCC and LOG_ODDS_FREE constants.
- Sub-module `log_odds_sat_add`: combinational saturating signed adder, parameterised by CELL_WIDTH.

## Test plan
- Occupied write to (x=3, y=5), RAM value 0 → `rd_addr`=0x0503 at t; `wr_en`=1, `wr_addr`=0x0503, `wr_data`=9 at t+2.
- Four back-to-back free writes to (7,7), RAM value 0 → `wr_data` = -3, -6, -9, -12 on four consecutive cycles (exercises S2 forwarding).
- Address sequence A, B, A, each an occupied write, RAM value 0 → second write to A gives 18 (exercises S3 forwarding); B gives 9.
- Saturation: cell at 125, occupied → 127; cell at -127, free → -128.
- `clear` during a 10-cell stream:
  - The stream completes and the sweep then writes 0 to all 65536 addresses.
  - `occupancy_busy` falls one cycle after address 0xFFFF is written.
  - A `write_enable` during the sweep sets `overrun`=1 and produces no extra write.
- `reset_n` pulled low mid-sweep → `wr_en` and `occupancy_busy` drop to 0 immediately; after release the block is back in RUN and `overrun`=0.
